// File: rtl/nes_attr_pkg.sv
// Shared attribute-table definitions: bus widths, arbiter state type and
// the tile-to-attribute address/quadrant helpers used by the renderer path.
package nes_attr_pkg;

  localparam int ATTR_ADDR_W = 7;
  localparam int ATTR_DATA_W = 8;

  typedef enum logic {
    IDLE    = 1'b0,
    CPU_ACK = 1'b1
  } arb_state_e;

  // Attribute byte address: name table, 4x4-tile block row, 4x4-tile block column.
  function automatic logic [ATTR_ADDR_W-1:0] attr_addr(input logic       nt,
                                                       input logic [4:0] row,
                                                       input logic [4:0] col);
    return {nt, row[4:2], col[4:2]};
  endfunction

  // Bit offset of the 2x2-tile quadrant inside the attribute byte (0, 2, 4 or 6).
  function automatic logic [2:0] attr_quad_shift(input logic [4:0] row,
                                                 input logic [4:0] col);
    return {row[1], col[1], 1'b0};
  endfunction

  // Extract the 2-bit palette select for a quadrant from an attribute byte.
  function automatic logic [1:0] attr_pal_sel(input logic [ATTR_DATA_W-1:0] attr_byte,
                                              input logic [2:0]             shift);
    logic [ATTR_DATA_W-1:0] shifted;
    shifted = attr_byte >> shift;
    return shifted[1:0];
  endfunction

endpackage

// File: rtl/attr_cache_1e.sv
// Single-entry attribute cache: one tag/byte/valid set, hit compare and
// frame flush. A fill in the same cycle as a flush leaves the entry valid.
module attr_cache_1e
  import nes_attr_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush_i,
  input  logic                   fill_i,
  input  logic [ATTR_ADDR_W-1:0] fill_tag_i,
  input  logic [ATTR_DATA_W-1:0] fill_data_i,
  input  logic [ATTR_ADDR_W-1:0] lookup_tag_i,
  output logic                   hit_o,
  output logic [ATTR_DATA_W-1:0] data_o
);

  logic                   valid_q;
  logic [ATTR_ADDR_W-1:0] tag_q;
  logic [ATTR_DATA_W-1:0] data_q;

  // A flush in the lookup cycle already forces a miss so the entry is refetched.
  assign hit_o  = valid_q & (tag_q == lookup_tag_i) & ~flush_i;
  assign data_o = data_q;

  // Entry update: fill wins over flush, flush clears only the valid bit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      tag_q   <= 7'd0;
      data_q  <= 8'd0;
    end else if (fill_i) begin
      valid_q <= 1'b1;
      tag_q   <= fill_tag_i;
      data_q  <= fill_data_i;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_q;
    end
  end

endmodule

// File: rtl/attr_rom_arbiter.sv
// Attribute ROM sequencer: serves renderer palette lookups through a
// one-entry cache and fits CPU byte reads into cycles the renderer leaves free.
module attr_rom_arbiter
  import nes_attr_pkg::*;
#(
  parameter int CNT_W = 16
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             tile_req,
  input  logic             tile_nt,
  input  logic [4:0]       tile_row,
  input  logic [4:0]       tile_col,
  output logic             pal_valid,
  output logic [1:0]       pal,
  input  logic             cpu_req,
  input  logic [6:0]       cpu_addr,
  output logic             cpu_ack,
  output logic [7:0]       cpu_data,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [6:0]       rom_addr,
  input  logic [7:0]       rom_dout
);

  localparam logic [CNT_W-1:0] STALL_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] STALL_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  arb_state_e             state_q, state_d;
  logic                   pal_valid_q;
  logic [1:0]             pal_q, pal_d;
  logic                   cpu_ack_q;
  logic [7:0]             cpu_data_q, cpu_data_d;
  logic [CNT_W-1:0]       stall_q, stall_d;
  logic [ATTR_ADDR_W-1:0] rom_addr_q, rom_addr_d;

  logic [ATTR_ADDR_W-1:0] raddr_s;
  logic [2:0]             shift_s;
  logic                   cache_hit_s;
  logic [ATTR_DATA_W-1:0] cache_data_s;
  logic                   miss_s;
  logic                   grant_s;
  logic [ATTR_DATA_W-1:0] pal_byte_s;

  assign raddr_s = attr_addr(tile_nt, tile_row, tile_col);
  assign shift_s = attr_quad_shift(tile_row, tile_col);

  attr_cache_1e u_cache (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (frame_start),
    .fill_i       (miss_s),
    .fill_tag_i   (raddr_s),
    .fill_data_i  (rom_dout),
    .lookup_tag_i (raddr_s),
    .hit_o        (cache_hit_s),
    .data_o       (cache_data_s)
  );

  // Arbitration, next state and datapath selects; renderer misses always own the ROM.
  always_comb begin
    miss_s     = tile_req & ~cache_hit_s;
    grant_s    = 1'b0;
    state_d    = IDLE;
    rom_addr_d = rom_addr_q;
    stall_d    = stall_q;
    cpu_data_d = cpu_data_q;
    pal_d      = pal_q;
    pal_byte_s = cache_hit_s ? cache_data_s : rom_dout;

    case (state_q)
      IDLE: begin
        if (cpu_req && !miss_s) begin
          grant_s = 1'b1;
          state_d = CPU_ACK;
        end else if (cpu_req && (stall_q != STALL_MAX)) begin
          stall_d = stall_q + STALL_ONE;
        end else begin
          state_d = IDLE;
        end
      end
      CPU_ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (miss_s) begin
      rom_addr_d = raddr_s;
    end else if (grant_s) begin
      rom_addr_d = cpu_addr;
    end else begin
      rom_addr_d = rom_addr_q;
    end

    if (grant_s) begin
      cpu_data_d = rom_dout;
    end else begin
      cpu_data_d = cpu_data_q;
    end

    if (tile_req) begin
      pal_d = attr_pal_sel(pal_byte_s, shift_s);
    end else begin
      pal_d = pal_q;
    end
  end

  // State and output registers; reset drops any pending acknowledge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pal_valid_q <= 1'b0;
      pal_q       <= 2'd0;
      cpu_ack_q   <= 1'b0;
      cpu_data_q  <= 8'd0;
      stall_q     <= '0;
      rom_addr_q  <= 7'd0;
    end else begin
      state_q     <= state_d;
      pal_valid_q <= tile_req;
      pal_q       <= pal_d;
      cpu_ack_q   <= grant_s;
      cpu_data_q  <= cpu_data_d;
      stall_q     <= stall_d;
      rom_addr_q  <= rom_addr_d;
    end
  end

  assign pal_valid = pal_valid_q;
  assign pal       = pal_q;
  assign cpu_ack   = cpu_ack_q;
  assign cpu_data  = cpu_data_q;
  assign stall_cnt = stall_q;
  assign rom_addr  = rom_addr_d;

endmodule
